// File: rtl/stack_cmd_sequencer_if.sv
// Command, stack and result signals of the stack command sequencer.
// slave is the sequencer side; master is the command source plus the stack.
interface stack_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_opcode;
  logic [DATA_WIDTH-1:0] in_data;
  logic [2:0]            stk_opcode;
  logic [DATA_WIDTH-1:0] stk_data;
  logic [DATA_WIDTH-1:0] stk_result;
  logic                  stk_empty;
  logic                  stk_full;
  logic                  stk_overflow;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ovf;
  logic                  busy;
  logic                  err;
  logic [1:0]            err_code;

  modport slave (
    input  in_valid, in_opcode, in_data,
    input  stk_result, stk_empty, stk_full,
    input  stk_overflow,
    output in_ready, stk_opcode, stk_data,
    output res_valid, res_data, res_ovf,
    output busy, err, err_code
  );

  modport master (
    output in_valid, in_opcode, in_data,
    output stk_result, stk_empty, stk_full,
    output stk_overflow,
    input  in_ready, stk_opcode, stk_data,
    input  res_valid, res_data, res_ovf,
    input  busy, err, err_code
  );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// Buffers stack commands in a FIFO, checks operand counts,
// issues them one at a time and returns ADD/MUL/POP results.
module stack_cmd_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input logic clk,
  input logic rst,
  stack_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERROR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]            op_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  fault;
  logic [1:0]            fault_code;
  logic [2:0]            head_op;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  is_nop;
  logic                  is_push;
  logic                  is_pop;
  logic                  is_arith;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  arith_ok;
  logic [OW-1:0]         occ;
  logic [2:0]            cur_op;
  logic [2:0]            stk_opcode;
  logic [DATA_WIDTH-1:0] stk_data;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ovf;
  logic                  err;
  logic [1:0]            err_code;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_op    = op_mem[rptr[AW-1:0]];
  assign head_data  = data_mem[rptr[AW-1:0]];

  assign bus.in_ready = !fifo_full && (state != ERROR);
  assign push = bus.in_valid && bus.in_ready;

  assign is_nop   = (head_op == OP_NOP);
  assign is_push  = (head_op == OP_PUSH);
  assign is_pop   = (head_op == OP_POP);
  assign is_arith = (head_op == OP_ADD) ||
                    (head_op == OP_MUL);

  assign push_ok  = (occ < OW'(STACK_DEPTH)) &&
                    !bus.stk_full;
  assign pop_ok   = (occ != '0) && !bus.stk_empty;
  assign arith_ok = (occ >= OW'(2));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    issue      = 1'b0;
    fault      = 1'b0;
    fault_code = 2'b00;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          unique case (1'b1)
            is_nop: pop = 1'b1;
            is_push: begin
              if (push_ok) begin
                pop   = 1'b1;
                issue = 1'b1;
              end else begin
                fault      = 1'b1;
                fault_code = 2'b01;
              end
            end
            is_pop: begin
              if (pop_ok) begin
                pop   = 1'b1;
                issue = 1'b1;
              end else begin
                fault      = 1'b1;
                fault_code = 2'b10;
              end
            end
            is_arith: begin
              if (arith_ok) begin
                pop   = 1'b1;
                issue = 1'b1;
              end else begin
                fault      = 1'b1;
                fault_code = 2'b10;
              end
            end
            default: begin
              fault      = 1'b1;
              fault_code = 2'b11;
            end
          endcase
          if (issue) state_nx = ISSUE;
          if (fault) state_nx = ERROR;
        end
      end
      ISSUE:
        state_nx = (cur_op == OP_PUSH) ? IDLE : WAIT;
      WAIT:    state_nx = IDLE;
      ERROR:   state_nx = ERROR;
      default: state_nx = IDLE;
    endcase
  end

  // Storage is not reset; clearing the pointers discards it.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wptr[AW-1:0]]   <= bus.in_opcode;
      data_mem[wptr[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      occ        <= '0;
      cur_op     <= OP_NOP;
      stk_opcode <= OP_NOP;
      stk_data   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      stk_opcode <= OP_NOP;
      res_valid  <= 1'b0;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (issue) begin
        cur_op     <= head_op;
        stk_opcode <= head_op;
        stk_data   <= head_data;
      end
      if (state == ISSUE) begin
        if (cur_op == OP_PUSH) occ <= occ + 1'b1;
        else                   occ <= occ - 1'b1;
      end
      if (state == WAIT) begin
        res_valid <= 1'b1;
        res_data  <= bus.stk_result;
        res_ovf   <= (cur_op != OP_POP) &&
                     bus.stk_overflow;
      end
      if (fault) begin
        err      <= 1'b1;
        err_code <= fault_code;
      end
    end
  end

  assign bus.stk_opcode = stk_opcode;
  assign bus.stk_data   = stk_data;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_data;
  assign bus.res_ovf    = res_ovf;
  assign bus.err        = err;
  assign bus.err_code   = err_code;
  assign bus.busy       = !fifo_empty ||
                          (state != IDLE);
endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Bench for stack_cmd_sequencer: behavioural stack attached to the
// stack port, command-level reference model and result scoreboard.
module tb_stack_cmd_sequencer;
  localparam int DW = 16;
  localparam int SD = 16;
  localparam int FD = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stack_cmd_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  stack_cmd_sequencer #(
    .DATA_WIDTH (DW),
    .STACK_DEPTH(SD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  // Downstream stack: acts on the opcode seen at a clock edge,
  // its data_out/overflow are valid the following cycle.
  logic signed [DW-1:0] smem [SD];
  int                   sp   = 0;
  int                   seen = 0;
  logic [DW-1:0]        sres = '0;
  logic                 sovf = 1'b0;

  function automatic logic [DW:0] env_alu(
    input logic [2:0] op,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] x;
    logic signed [2*DW-1:0] y;
    logic signed [2*DW-1:0] w;
    x = a;
    y = b;
    w = (op == 3'b100) ? x + y : x * y;
    return {w != {{DW{w[DW-1]}}, w[DW-1:0]},
            w[DW-1:0]};
  endfunction

  assign bus.stk_result   = sres;
  assign bus.stk_overflow = sovf;
  assign bus.stk_empty    = (sp == 0);
  assign bus.stk_full     = (sp == SD);

  always @(posedge clk) begin
    if (rst) begin
      sp   <= 0;
      sres <= '0;
      sovf <= 1'b0;
    end else begin
      if (bus.stk_opcode != 3'b000) seen <= seen + 1;
      case (bus.stk_opcode)
        3'b110: if (sp < SD) begin
          smem[sp] <= bus.stk_data;
          sp       <= sp + 1;
        end
        3'b111: if (sp > 0) begin
          sres <= smem[sp-1];
          sovf <= 1'b0;
          sp   <= sp - 1;
        end
        3'b100, 3'b101: if (sp >= 2) begin
          {sovf, sres} <= env_alu(bus.stk_opcode,
                                  smem[sp-1], smem[sp-2]);
          smem[sp-2] <= DW'(env_alu(bus.stk_opcode,
                                    smem[sp-1], smem[sp-2]));
          sp <= sp - 1;
        end
        default: ;
      endcase
    end
  end

  // Reference model at command granularity
  exp_t       exp_q [$];
  int         mstk  [$];
  bit         merr;
  logic [1:0] mcode;
  int         missued;
  int         base;

  task automatic model_err(input logic [1:0] c);
    merr  = 1'b1;
    mcode = c;
  endtask

  task automatic model_cmd(input logic [2:0] op,
                           input logic [DW-1:0] d);
    int a, b, f, r;
    bit o;
    if (merr) return;
    case (op)
      3'b000: ;
      3'b110: begin
        if (mstk.size() < SD) begin
          mstk.push_back(int'($signed(d)));
          missued++;
        end else model_err(2'b01);
      end
      3'b111: begin
        if (mstk.size() >= 1) begin
          a = mstk.pop_back();
          exp_q.push_back('{d: DW'(a), o: 1'b0});
          missued++;
        end else model_err(2'b10);
      end
      3'b100, 3'b101: begin
        if (mstk.size() >= 2) begin
          a = mstk.pop_back();
          b = mstk.pop_back();
          f = (op == 3'b100) ? a + b : a * b;
          r = f & ((1 << DW) - 1);
          if (r >= (1 << (DW - 1))) r = r - (1 << DW);
          o = (r != f);
          mstk.push_back(r);
          exp_q.push_back('{d: DW'(r), o: o});
          missued++;
        end else model_err(2'b10);
      end
      default: model_err(2'b11);
    endcase
  endtask

  // Result monitor
  exp_t got;
  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none",
                 bus.res_data);
      end else begin
        got = exp_q.pop_front();
        check("res_data", 32'(bus.res_data), 32'(got.d));
        check("res_ovf", 32'(bus.res_ovf), 32'(got.o));
      end
    end
  end

  // Call at a negedge; returns at a negedge with rst released.
  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    mstk.delete();
    merr    = 1'b0;
    mcode   = 2'b00;
    missued = 0;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    check("rst_res_ovf", 32'(bus.res_ovf), 0);
    check("rst_stk_opcode", 32'(bus.stk_opcode), 0);
    rst  = 1'b0;
    base = seen;
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [DW-1:0] d);
    int n;
    n = 0;
    if (merr) return;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_data   = d;
    while (!bus.in_ready && n < 300) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_cmd(op, d);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.busy && !bus.err && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_settle"}, 32'(n < 500), 1);
    repeat (4) @(negedge clk);
    check({tag, "_pending"}, 32'(exp_q.size()), 0);
    check({tag, "_err"}, 32'(bus.err), 32'(merr));
    check({tag, "_err_code"}, 32'(bus.err_code), 32'(mcode));
    check({tag, "_issued"}, 32'(seen - base), 32'(missued));
    if (merr) check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]    op;
    logic [DW-1:0] d;
    int            pick;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 3'b000;
    bus.in_data   = '0;

    do_reset();
    send(3'b110, 16'd3);
    send(3'b110, 16'd5);
    send(3'b100, 16'd0);
    drain("t1");

    do_reset();
    send(3'b110, 16'd32767);
    send(3'b110, 16'd2);
    send(3'b100, 16'd0);
    drain("t2");

    do_reset();
    send(3'b110, -16'sd20);
    send(3'b110, -16'sd5);
    send(3'b101, 16'd0);
    send(3'b110, 16'd256);
    send(3'b110, 16'd128);
    send(3'b101, 16'd0);
    drain("t3");

    do_reset();
    for (int i = 0; i < 17; i++) send(3'b110, DW'(i + 1));
    drain("t4");

    do_reset();
    send(3'b100, 16'd0);
    drain("t5a");
    do_reset();
    send(3'b011, 16'd0);
    drain("t5b");

    do_reset();
    stalls = 0;
    send(3'b110, 16'd7);
    send(3'b110, 16'd9);
    for (int i = 0; i < 7; i++) begin
      send(3'b100, 16'd0);
      send(3'b110, DW'(i * 100));
    end
    check("t6_backpressure", 32'(stalls > 0), 1);
    drain("t6");

    do_reset();
    send(3'b110, 16'd11);
    send(3'b110, 16'd22);
    send(3'b100, 16'd0);
    idle(0);
    n = 0;
    while (bus.stk_opcode != 3'b100 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_add_issued", 32'(bus.stk_opcode), 32'h4);
    @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    check("t6_post_rst_busy", 32'(bus.busy), 0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 0; k < 40 && !merr; k++) begin
        pick = $urandom_range(0, 99);
        if      (pick < 45) op = 3'b110;
        else if (pick < 60) op = 3'b100;
        else if (pick < 72) op = 3'b101;
        else if (pick < 85) op = 3'b111;
        else if (pick < 95) op = 3'b000;
        else                op = 3'($urandom_range(1, 3));
        if (op[2] && op != 3'b110 && mstk.size() < 2 &&
            $urandom_range(0, 3) != 0)
          op = 3'b110;
        if ($urandom_range(0, 1) == 1) d = DW'($urandom);
        else d = DW'($urandom_range(0, 40)) - DW'(20);
        send(op, d);
        if ($urandom_range(0, 2) == 0)
          idle($urandom_range(0, 3));
      end
      drain("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
